// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : 4-entry {pc,instr} FIFO between PC/IMEM and decode; optional
//               empty-queue bypass under FETCH_QUEUE_BYPASS_EN.   Rev 1.0
// ============================================================================
module fetch_queue (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_addr,
  input  logic [31:0] instr_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        flush,
  output logic [2:0]  count
);

  logic [31:0] pc_mem    [4];
  logic [31:0] instr_mem [4];
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;
  logic        empty;
  logic        bypass;
  logic        push;
  logic        pop;

  assign empty    = (count == 3'd0);
  // count never exceeds 4, so bit 2 alone marks full
  assign in_ready = ~count[2];

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty & in_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed pair that decode takes immediately is never written
  assign push = in_valid & in_ready & ~flush & ~(bypass & out_ready);
  assign pop  = ~empty & out_ready & ~flush;

  always_comb begin
    out_valid = ~empty;
    out_pc    = 32'h0;
    out_instr = 32'h0;
    if (!empty) begin
      out_pc    = pc_mem[rd_ptr];
      out_instr = instr_mem[rd_ptr];
    end else if (bypass) begin
      out_valid = 1'b1;
      out_pc    = pc_addr;
      out_instr = instr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc_addr;
      instr_mem[wr_ptr] <= instr_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
    end else if (flush) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_fetch_queue : table-driven self-checking bench for fetch_queue.  Rev 1.0
// ============================================================================
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_addr;
  logic [31:0] instr_in;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        flush;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk       (clk),
    .reset     (reset),
    .pc_addr   (pc_addr),
    .instr_in  (instr_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .flush     (flush),
    .count     (count)
  );

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic        e_ir;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] wd(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  // Expected value that differs between bypass and default builds
  function automatic logic [31:0] bs(input logic [31:0] b, input logic [31:0] d);
    return BYP ? b : d;
  endfunction

  task automatic add(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                     input logic ordy, input logic fl, input logic e_ov,
                     input logic [31:0] e_pc, input logic [31:0] e_ins,
                     input logic e_ir, input logic [2:0] e_cnt);
    vec_t v;
    v.iv = iv; v.pc = pc; v.ins = ins; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_pc = e_pc; v.e_ins = e_ins; v.e_ir = e_ir; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic [31:0] pc,
                         input logic [31:0] ins, input logic ir, input logic [2:0] cnt);
    chk({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, ov});
    chk({tag, " out_pc"},    out_pc, pc);
    chk({tag, " out_instr"}, out_instr, ins);
    chk({tag, " in_ready"},  {31'b0, in_ready}, {31'b0, ir});
    chk({tag, " count"},     {29'b0, count}, {29'b0, cnt});
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    in_valid = iv; pc_addr = pc; instr_in = ins; out_ready = ordy; flush = fl;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Two-entry fill then drain
    add(1, 32'h3000, 32'h24010001, 0, 0, BYP, bs(32'h3000, 0), bs(32'h24010001, 0), 1, 0);
    add(1, 32'h3004, 32'h24020002, 0, 0, 1, 32'h3000, 32'h24010001, 1, 1);
    add(0, 32'h0, 32'h0, 1, 0, 1, 32'h3000, 32'h24010001, 1, 2);
    add(0, 32'h0, 32'h0, 1, 0, 1, 32'h3004, 32'h24020002, 1, 1);
    add(0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0);
    // Fill to full, hold a fifth pair, pop once, fifth enters
    add(1, 32'h3000, wd(32'h3000), 0, 0, BYP, bs(32'h3000, 0), bs(wd(32'h3000), 0), 1, 0);
    add(1, 32'h3004, wd(32'h3004), 0, 0, 1, 32'h3000, wd(32'h3000), 1, 1);
    add(1, 32'h3008, wd(32'h3008), 0, 0, 1, 32'h3000, wd(32'h3000), 1, 2);
    add(1, 32'h300C, wd(32'h300C), 0, 0, 1, 32'h3000, wd(32'h3000), 1, 3);
    add(1, 32'h3010, wd(32'h3010), 0, 0, 1, 32'h3000, wd(32'h3000), 0, 4);
    add(1, 32'h3010, wd(32'h3010), 1, 0, 1, 32'h3000, wd(32'h3000), 0, 4);
    add(1, 32'h3010, wd(32'h3010), 0, 0, 1, 32'h3004, wd(32'h3004), 1, 3);
    add(0, 32'h0, 32'h0, 1, 0, 1, 32'h3004, wd(32'h3004), 0, 4);
    add(0, 32'h0, 32'h0, 1, 0, 1, 32'h3008, wd(32'h3008), 1, 3);
    add(0, 32'h0, 32'h0, 1, 0, 1, 32'h300C, wd(32'h300C), 1, 2);
    add(0, 32'h0, 32'h0, 1, 0, 1, 32'h3010, wd(32'h3010), 1, 1);
    add(0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0);
    // Count 3 then flush with concurrent push and pop
    add(1, 32'h3000, wd(32'h3000), 0, 0, BYP, bs(32'h3000, 0), bs(wd(32'h3000), 0), 1, 0);
    add(1, 32'h3004, wd(32'h3004), 0, 0, 1, 32'h3000, wd(32'h3000), 1, 1);
    add(1, 32'h3008, wd(32'h3008), 0, 0, 1, 32'h3000, wd(32'h3000), 1, 2);
    add(1, 32'h300C, wd(32'h300C), 1, 1, 1, 32'h3000, wd(32'h3000), 1, 3);
    add(0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0);
    // Streaming six pairs with continuous pop; pointers wrap
    add(1, 32'h3000, wd(32'h3000), 1, 0, BYP, bs(32'h3000, 0), bs(wd(32'h3000), 0), 1, 0);
    for (int k = 1; k < 6; k++) begin
      logic [31:0] a;
      logic [31:0] p;
      a = 32'h3000 + 32'(4 * k);
      p = a - 32'h4;
      add(1, a, wd(a), 1, 0, 1, bs(a, p), bs(wd(a), wd(p)), 1, BYP ? 3'd0 : 3'd1);
    end
    add(0, 32'h0, 32'h0, 1, 0, !BYP, bs(0, 32'h3014), bs(0, wd(32'h3014)), 1, BYP ? 3'd0 : 3'd1);
    add(0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0);

    // Reset state while held low
    #3;
    chk_all("reset_low", 1'b0, 32'h0, 32'h0, 1'b1, 3'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk_all("reset_rel", 1'b0, 32'h0, 32'h0, 1'b1, 3'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].pc, vecs[i].ins, vecs[i].ordy, vecs[i].fl);
      @(negedge clk);
      chk_all($sformatf("row%0d", i), vecs[i].e_ov, vecs[i].e_pc, vecs[i].e_ins,
              vecs[i].e_ir, vecs[i].e_cnt);
      @(posedge clk); #1;
    end

    // Empty-queue latency: same-cycle only with bypass
    drive(1'b1, 32'h3008, wd(32'h3008), 1'b1, 1'b0);
    @(negedge clk);
    chk_all("lat_same", BYP, bs(32'h3008, 0), bs(wd(32'h3008), 0), 1'b1, 3'd0);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk_all("lat_next", !BYP, bs(0, 32'h3008), bs(0, wd(32'h3008)), 1'b1, BYP ? 3'd0 : 3'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk_all("lat_drain", 1'b0, 32'h0, 32'h0, 1'b1, 3'd0);
    @(posedge clk); #1;

    // Asynchronous reset mid-operation, then a fresh head
    drive(1'b1, 32'h3000, wd(32'h3000), 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 32'h3004, wd(32'h3004), 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 32'h0, 32'h0, 1'b1, 3'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b1, 32'h3020, wd(32'h3020), 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk_all("post_rst", 1'b1, 32'h3020, wd(32'h3020), 1'b1, 3'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
